// File: rtl/spi_avalon_master.sv
// -----------------------------------------------------------------------------
// spi_avalon_master
//
// Avalon-MM SPI master with an internal shift engine. It has a configurable
// word width, NUM_CS active-low chip selects and a run-time CPOL/CPHA mode.
// It also provides a sticky done flag, overrun detection and a level
// interrupt.
//
// Register map (word addresses, unused bits read 0):
//   0 RXDATA (R)  [DATA_W-1:0] last received word
//   1 CS     (RW) [NUM_CS-1:0] value driven onto spi_cs_n
//   2 DVSR   (RW) [DVSR_W-1:0] each SCLK half-phase lasts DVSR+1 clocks
//   3 TXDATA (W)  a write starts a transfer; reads 0
//   4 CTRL   (RW) [0] cpol [1] cpha [2] irq_en
//                 with SPI_AUTO_CS_EN also: [3] auto_cs [7:4] sel
//   5 STATUS      [0] done (W1C) [1] overrun (W1C) [2] busy (RO)
//   6,7           read 0, writes ignored
//
// Optional feature macro: SPI_AUTO_CS_EN. When it is defined and auto_cs=1,
// spi_cs_n[sel] is driven low while a transfer is busy. When it is
// undefined, CTRL[7:3] reads 0.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   spi_chipselect, spi_write  Avalon write qualifiers
//   spi_address[2:0]           register word address
//   spi_writedata[31:0]        write data
//   spi_readdata[31:0]         read data, combinational on spi_address
//   spi_irq                    done & irq_en
//   spi_cs_n[NUM_CS-1:0]       chip selects, active low
//   spi_sclk, spi_mosi         SPI clock and serial data out
//   spi_miso                   serial data in
// -----------------------------------------------------------------------------
module spi_avalon_master #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DVSR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_chipselect,
    input  logic              spi_write,
    input  logic [2:0]        spi_address,
    input  logic [31:0]       spi_writedata,
    output logic [31:0]       spi_readdata,
    output logic              spi_irq,
    output logic [NUM_CS-1:0] spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int BCNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, CPHA_DLY, P0, P1} state_t;

    state_t              state_q, state_d;
    logic [DVSR_W-1:0]   cnt_q, cnt_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [NUM_CS-1:0]   cs_q, cs_d;
    logic [DVSR_W-1:0]   dvsr_q, dvsr_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                irq_en_q, irq_en_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    // Per-transfer copies, so register writes during a transfer only
    // take effect on the next one.
    logic                lat_cpol_q, lat_cpol_d;
    logic                lat_cpha_q, lat_cpha_d;
    logic [DVSR_W-1:0]   lat_dvsr_q, lat_dvsr_d;
`ifdef SPI_AUTO_CS_EN
    logic                auto_cs_q, auto_cs_d;
    logic [3:0]          sel_q, sel_d;
`endif

    logic wr_en;
    logic busy;
    logic phase_end;
    logic unused_wdata;

    assign wr_en        = spi_chipselect & spi_write;
    assign busy         = (state_q != IDLE);
    assign phase_end    = (cnt_q == lat_dvsr_q);
    assign unused_wdata = ^spi_writedata;

    // Next-state logic. Register writes are handled first and the engine
    // second, so that an engine set of done overrides a write-1-clear in
    // the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        cs_d       = cs_q;
        dvsr_d     = dvsr_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        overrun_d  = overrun_q;
        lat_cpol_d = lat_cpol_q;
        lat_cpha_d = lat_cpha_q;
        lat_dvsr_d = lat_dvsr_q;
`ifdef SPI_AUTO_CS_EN
        auto_cs_d  = auto_cs_q;
        sel_d      = sel_q;
`endif

        if (wr_en) begin
            unique case (spi_address)
                3'd1: cs_d   = spi_writedata[NUM_CS-1:0];
                3'd2: dvsr_d = spi_writedata[DVSR_W-1:0];
                3'd3: if (busy) overrun_d = 1'b1;
                3'd4: begin
                    cpol_d   = spi_writedata[0];
                    cpha_d   = spi_writedata[1];
                    irq_en_d = spi_writedata[2];
`ifdef SPI_AUTO_CS_EN
                    auto_cs_d = spi_writedata[3];
                    sel_d     = spi_writedata[7:4];
`endif
                end
                3'd5: begin
                    if (spi_writedata[0]) done_d    = 1'b0;
                    if (spi_writedata[1]) overrun_d = 1'b0;
                end
                default: ;
            endcase
        end

        unique case (state_q)
            IDLE: begin
                if (wr_en && spi_address == 3'd3) begin
                    tx_sh_d    = spi_writedata[DATA_W-1:0];
                    lat_cpol_d = cpol_q;
                    lat_cpha_d = cpha_q;
                    lat_dvsr_d = dvsr_q;
                    cnt_d      = '0;
                    bit_cnt_d  = '0;
                    done_d     = 1'b0;
                    state_d    = cpha_q ? CPHA_DLY : P0;
                end
            end
            default: begin
                if (!phase_end) begin
                    cnt_d = cnt_q + DVSR_W'(1);
                end else begin
                    cnt_d = '0;
                    unique case (state_q)
                        CPHA_DLY: state_d = P0;
                        P0: begin
                            rx_sh_d   = (rx_sh_q << 1) | DATA_W'(spi_miso);
                            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                            state_d   = P1;
                        end
                        default: begin // P1
                            if (bit_cnt_q < BCNT_W'(DATA_W)) begin
                                tx_sh_d = tx_sh_q << 1;
                                state_d = P0;
                            end else begin
                                rx_data_d = rx_sh_q;
                                done_d    = 1'b1;
                                state_d   = IDLE;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            cs_q       <= '1;
            dvsr_q     <= '1;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            lat_cpol_q <= 1'b0;
            lat_cpha_q <= 1'b0;
            lat_dvsr_q <= '0;
`ifdef SPI_AUTO_CS_EN
            auto_cs_q  <= 1'b0;
            sel_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            cs_q       <= cs_d;
            dvsr_q     <= dvsr_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            lat_cpol_q <= lat_cpol_d;
            lat_cpha_q <= lat_cpha_d;
            lat_dvsr_q <= lat_dvsr_d;
`ifdef SPI_AUTO_CS_EN
            auto_cs_q  <= auto_cs_d;
            sel_q      <= sel_d;
`endif
        end
    end

    // Read mux
    always_comb begin
        spi_readdata = '0;
        unique case (spi_address)
            3'd0: spi_readdata[DATA_W-1:0] = rx_data_q;
            3'd1: spi_readdata[NUM_CS-1:0] = cs_q;
            3'd2: spi_readdata[DVSR_W-1:0] = dvsr_q;
            3'd4: begin
                spi_readdata[2:0] = {irq_en_q, cpha_q, cpol_q};
`ifdef SPI_AUTO_CS_EN
                spi_readdata[3]   = auto_cs_q;
                spi_readdata[7:4] = sel_q;
`endif
            end
            3'd5: spi_readdata[2:0] = {busy, overrun_q, done_q};
            default: ;
        endcase
    end

    // SCLK toggles between P0 and P1. CPHA shifts which half is active.
    always_comb begin
        spi_sclk = cpol_q;
        unique case (state_q)
            IDLE:     spi_sclk = cpol_q;
            CPHA_DLY: spi_sclk = lat_cpol_q;
            P0:       spi_sclk = lat_cpol_q ^ lat_cpha_q;
            default:  spi_sclk = lat_cpol_q ^ ~lat_cpha_q;
        endcase
    end

    // A one-hot shift by sel yields an empty mask once sel >= NUM_CS.
    always_comb begin
        spi_cs_n = cs_q;
`ifdef SPI_AUTO_CS_EN
        if (auto_cs_q && busy)
            spi_cs_n = cs_q & ~(NUM_CS'(1) << sel_q);
`endif
    end

    assign spi_mosi = tx_sh_q[DATA_W-1];
    assign spi_irq  = done_q & irq_en_q;

endmodule

// File: tb/tb_spi_avalon_master.sv
module tb_spi_avalon_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel8, sel16, wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rd8, rd16;
    logic        irq8, irq16;
    logic [3:0]  csn8, csn16;
    logic        sclk8, sclk16, mosi8, mosi16, miso8, miso16;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    // Slave model for the 8-bit unit. On each rising SCLK it presents the
    // next bit of slave_pat MSB first. Otherwise the unit loops back.
    logic        use_slave;
    logic [7:0]  slave_pat;
    int unsigned base;
    int unsigned rise_cnt = 0;
    logic [7:0]  mosi_log = '0;
    logic        slave_bit;

    always #5 clk = ~clk;

    always @(posedge sclk8) begin
        rise_cnt <= rise_cnt + 1;
        mosi_log <= {mosi_log[6:0], mosi8};
    end

    assign slave_bit = ((rise_cnt - base) < 8) ? slave_pat[3'(7 - (rise_cnt - base))] : 1'b0;
    assign miso8     = use_slave ? slave_bit : mosi8;
    assign miso16    = mosi16;

    spi_avalon_master #(.DATA_W(8), .NUM_CS(4), .DVSR_W(8)) u8 (
        .clk(clk), .reset(rst), .spi_chipselect(sel8), .spi_write(wr),
        .spi_address(addr), .spi_writedata(wdata), .spi_readdata(rd8),
        .spi_irq(irq8), .spi_cs_n(csn8), .spi_sclk(sclk8),
        .spi_mosi(mosi8), .spi_miso(miso8)
    );

    spi_avalon_master #(.DATA_W(16), .NUM_CS(4), .DVSR_W(8)) u16 (
        .clk(clk), .reset(rst), .spi_chipselect(sel16), .spi_write(wr),
        .spi_address(addr), .spi_writedata(wdata), .spi_readdata(rd16),
        .spi_irq(irq16), .spi_cs_n(csn16), .spi_sclk(sclk16),
        .spi_mosi(mosi16), .spi_miso(miso16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input bit u16sel, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        sel8  = !u16sel;
        sel16 = u16sel;
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        sel8  = 1'b0;
        sel16 = 1'b0;
        wr    = 1'b0;
    endtask

    task automatic bus_rd(input bit u16sel, input logic [2:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = u16sel ? rd16 : rd8;
    endtask

    // Counts busy cycles starting at the first falling edge after the
    // TXDATA write. Also counts cycles where cs_n differs from cs_busy.
    task automatic wait_done(input bit u16sel, input logic [3:0] cs_busy,
                             output int cycles, output int cs_bad);
        logic [31:0] st;
        cycles = 0;
        cs_bad = 0;
        forever begin
            bus_rd(u16sel, 3'd5, st);
            if (!st[2]) break;
            if ((u16sel ? csn16 : csn8) !== cs_busy) cs_bad++;
            cycles++;
            if (cycles > 20000) begin
                check("done_timeout_busy", 32'(st[2]), 32'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic collect(input bit u16sel, input string tag);
        logic [31:0] got;
        bus_rd(u16sel, 3'd0, got);
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        else check(tag, got, exp_q.pop_front());
    endtask

    task automatic xfer(input bit u16sel, input string tag, input logic [31:0] tx,
                        input logic [31:0] rx_exp, input logic [3:0] cs_busy,
                        output int cycles, output int cs_bad);
        exp_q.push_back(rx_exp);
        bus_wr(u16sel, 3'd3, tx);
        wait_done(u16sel, cs_busy, cycles, cs_bad);
        collect(u16sel, tag);
    endtask

    initial begin
        logic [31:0] r;
        int cyc, bad, d;
        logic [7:0] pat;

        rst = 1'b1; sel8 = 1'b0; sel16 = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        use_slave = 1'b0; slave_pat = '0; base = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_csn", 32'(csn8), 32'hF);
        check("rst_sclk", 32'(sclk8), 32'd0);
        check("rst_mosi", 32'(mosi8), 32'd0);
        check("rst_irq", 32'(irq8), 32'd0);
        bus_rd(0, 3'd5, r); check("rst_status", r, 32'd0);
        bus_rd(0, 3'd2, r); check("rst_dvsr", r, 32'hFF);
        bus_rd(0, 3'd1, r); check("rst_cs", r, 32'hF);
        bus_rd(0, 3'd0, r); check("rst_rxdata", r, 32'd0);
        bus_rd(0, 3'd4, r); check("rst_ctrl", r, 32'd0);
        rst = 1'b0;

        // CS register drives spi_cs_n; addresses 3, 6, 7 read 0
        bus_wr(0, 3'd1, 32'h5);
        check("cs_drive", 32'(csn8), 32'h5);
        bus_wr(0, 3'd1, 32'hF);
        bus_wr(0, 3'd6, 32'hFFFF_FFFF);
        bus_rd(0, 3'd6, r); check("addr6_zero", r, 32'd0);
        bus_rd(0, 3'd7, r); check("addr7_zero", r, 32'd0);
        bus_rd(0, 3'd3, r); check("txdata_reads0", r, 32'd0);

        // Mode 0 loopback
        bus_wr(0, 3'd2, 32'd1);
        bus_wr(0, 3'd4, 32'd0);
        base = rise_cnt;
        xfer(0, "m0_rx", 32'hA5, 32'hA5, 4'hF, cyc, bad);
        check("m0_busy_cycles", 32'(cyc), 32'd32);
        check("m0_sclk_rises", 32'(rise_cnt - base), 32'd8);
        check("m0_mosi_seq", 32'(mosi_log), 32'hA5);
        check("m0_cs_during", 32'(bad), 32'd0);
        bus_rd(0, 3'd5, r); check("m0_status", r, 32'h1);
        check("m0_irq_disabled", 32'(irq8), 32'd0);

        // Mode 3, DVSR=0, slave returns 0x3C, irq enabled
        bus_wr(0, 3'd4, 32'h7);
        bus_wr(0, 3'd2, 32'd0);
        check("m3_sclk_idle", 32'(sclk8), 32'd1);
        use_slave = 1'b1;
        slave_pat = 8'h3C;
        base = rise_cnt;
        xfer(0, "m3_rx", 32'h96, 32'h3C, 4'hF, cyc, bad);
        check("m3_busy_cycles", 32'(cyc), 32'd17);
        check("m3_mosi_seq", 32'(mosi_log), 32'h96);
        check("m3_irq", 32'(irq8), 32'd1);
        check("m3_sclk_after", 32'(sclk8), 32'd1);
        bus_wr(0, 3'd5, 32'h1);
        check("m3_irq_cleared", 32'(irq8), 32'd0);
        use_slave = 1'b0;

        // Overrun: the second TXDATA write while busy is dropped
        bus_wr(0, 3'd4, 32'd0);
        bus_wr(0, 3'd2, 32'd1);
        exp_q.push_back(32'h11);
        bus_wr(0, 3'd3, 32'h11);
        bus_wr(0, 3'd3, 32'h22);
        wait_done(0, 4'hF, cyc, bad);
        collect(0, "ovr_rx");
        check("ovr_mosi_seq", 32'(mosi_log), 32'h11);
        bus_rd(0, 3'd5, r); check("ovr_status", r, 32'h3);
        bus_wr(0, 3'd5, 32'h3);
        bus_rd(0, 3'd5, r); check("ovr_w1c", r, 32'h0);

        // All four modes with random data and divisor
        for (int i = 0; i < 4; i++) begin
            d   = int'($urandom_range(0, 2));
            pat = 8'($urandom);
            bus_wr(0, 3'd4, 32'(i));
            bus_wr(0, 3'd2, 32'(d));
            xfer(0, "mode_rx", {24'd0, pat}, {24'd0, pat}, 4'hF, cyc, bad);
            check("mode_cycles", 32'(cyc), 32'(16 * (d + 1) + (((i & 2) != 0) ? d + 1 : 0)));
        end

        // Auto chip select
        bus_wr(0, 3'd2, 32'd0);
        bus_wr(0, 3'd4, 32'h28);
`ifdef SPI_AUTO_CS_EN
        bus_rd(0, 3'd4, r); check("ctrl_readback", r, 32'h28);
        xfer(0, "acs_rx", 32'h5A, 32'h5A, 4'b1011, cyc, bad);
        check("acs_cs_busy", 32'(bad), 32'd0);
        check("acs_cs_idle", 32'(csn8), 32'hF);
        bus_wr(0, 3'd4, 32'h58);
        xfer(0, "acs5_rx", 32'hC3, 32'hC3, 4'hF, cyc, bad);
        check("acs_sel5_cs", 32'(bad), 32'd0);
`else
        bus_rd(0, 3'd4, r); check("ctrl_readback", r, 32'h0);
        xfer(0, "nacs_rx", 32'h5A, 32'h5A, 4'hF, cyc, bad);
        check("nacs_cs_busy", 32'(bad), 32'd0);
`endif

        // 16-bit unit: reset mid-transfer, then a clean transfer
        bus_wr(1, 3'd2, 32'd0);
        bus_wr(1, 3'd4, 32'd0);
        bus_wr(1, 3'd3, 32'hBEEF);
        repeat (5) @(negedge clk);
        bus_rd(1, 3'd5, r); check("w16_busy_mid", r, 32'h4);
        rst = 1'b1;
        @(negedge clk);
        check("abort_csn", 32'(csn16), 32'hF);
        check("abort_sclk", 32'(sclk16), 32'd0);
        check("abort_mosi", 32'(mosi16), 32'd0);
        check("abort_irq", 32'(irq16), 32'd0);
        bus_rd(1, 3'd5, r); check("abort_status", r, 32'd0);
        bus_rd(1, 3'd2, r); check("abort_dvsr", r, 32'hFF);
        bus_rd(1, 3'd0, r); check("abort_rxdata", r, 32'd0);
        rst = 1'b0;
        bus_wr(1, 3'd2, 32'd0);
        xfer(1, "w16_rx", 32'hBEEF, 32'hBEEF, 4'hF, cyc, bad);
        check("w16_cycles", 32'(cyc), 32'd32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
